fp_add_sequencer: RTL

Multi-cycle controller and datapath for double-precision (IEEE 754 binary64) add/subtract in the floating-point ALU. An FSM sequences unpack, operand swap, one-bit-per-cycle mantissa alignment driven by the unbiased exponent difference, add/subtract, iterative normalization and pack. The integer pipeline issues a request with a start/done handshake and stalls on `busy`. Rounding is truncation and subnormals flush to zero.

---
 rtl/fp_add_pkg.sv | 32 +++
 rtl/fp_operand_unpack.sv | 70 +++++++
 rtl/fp_add_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the sequential binary64 add/subtract unit:
// FSM state encoding, binary64 field positions and special encodings.
package fp_add_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_PACK,
      S_DONE
   } state_t;

   localparam int          BIAS    = 1023;
   localparam logic [10:0] EXP_MAX = 11'd2047;
   localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;

   localparam int SIGN_BIT = 63;
   localparam int EXP_HI   = 62;
   localparam int EXP_LO   = 52;
   localparam int FRAC_HI  = 51;
   localparam int FRAC_LO  = 0;
   localparam int EXP_W    = 11;
   localparam int FRAC_W   = 52;

   // Hidden one in front of the fraction, two guard bits below it.
   function automatic logic [FRAC_W+2:0] unpack_mant(input logic [FRAC_W-1:0] frac);
      return {1'b1, frac, 2'b00};
   endfunction

endpackage

// File: rtl/fp_operand_unpack.sv
// Combinational operand front end: field split, zero/special screening,
// magnitude ordering and exponent difference for the add sequencer.
module fp_operand_unpack
   import fp_add_pkg::*;
#(
   parameter int MANT_W = 56
) (
   input  logic [63:0]       a,
   input  logic [63:0]       b,
   input  logic              sub,
   output logic              early,
   output logic              special,
   output logic [63:0]       early_result,
   output logic              sign_l,
   output logic              sign_s,
   output logic [EXP_W-1:0]  exp_l,
   output logic [EXP_W-1:0]  diff,
   output logic [MANT_W-1:0] mant_l,
   output logic [MANT_W-1:0] mant_s
);
   logic              sign_a, sign_b;
   logic [EXP_W-1:0]  exp_a, exp_b;
   logic [FRAC_W-1:0] frac_a, frac_b;
   logic              zero_a, zero_b, a_larger;

   assign sign_a  = a[SIGN_BIT];
   assign sign_b  = b[SIGN_BIT] ^ sub;
   assign exp_a   = a[EXP_HI:EXP_LO];
   assign exp_b   = b[EXP_HI:EXP_LO];
   assign frac_a  = a[FRAC_HI:FRAC_LO];
   assign frac_b  = b[FRAC_HI:FRAC_LO];

   // A zero exponent means zero here, which also flushes subnormals.
   assign zero_a   = (exp_a == '0);
   assign zero_b   = (exp_b == '0);
   assign special  = (exp_a == EXP_MAX) || (exp_b == EXP_MAX);
   assign early    = special || zero_a || zero_b;
   assign a_larger = ({exp_a, frac_a} >= {exp_b, frac_b});

   always_comb begin
      early_result = '0;
      if (special) begin
         early_result = QNAN;
      end else if (zero_a && zero_b) begin
         early_result = {sign_a & sign_b, 63'd0};
      end else if (zero_a) begin
         early_result = {sign_b, b[EXP_HI:0]};
      end else if (zero_b) begin
         early_result = a;
      end
   end

   always_comb begin
      sign_l = sign_a;
      sign_s = sign_b;
      exp_l  = exp_a;
      diff   = exp_a - exp_b;
      mant_l = MANT_W'(unpack_mant(frac_a));
      mant_s = MANT_W'(unpack_mant(frac_b));
      if (!a_larger) begin
         sign_l = sign_b;
         sign_s = sign_a;
         exp_l  = exp_b;
         diff   = exp_b - exp_a;
         mant_l = MANT_W'(unpack_mant(frac_b));
         mant_s = MANT_W'(unpack_mant(frac_a));
      end
   end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary64 add/subtract: FSM-sequenced unpack, serial alignment,
// add/subtract, serial normalization and pack (truncating, flush-to-zero).
module fp_add_sequencer
   import fp_add_pkg::*;
#(
   parameter int MANT_W = 56
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sub,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] result,
   output logic        invalid
);
   // Handshake: start is taken only in IDLE; busy is high from the next cycle
   // until DONE exits; done pulses one cycle with result/invalid already valid.
   localparam int CARRY  = MANT_W - 1;
   localparam int HIDDEN = MANT_W - 2;

   state_t            state, state_nx;
   logic [63:0]       a_q, b_q;
   logic              sub_q;
   logic              sign_a, sign_b;
   logic [EXP_W-1:0]  exp_r, cnt;
   logic [MANT_W-1:0] ma, mb, m;

   logic              u_early, u_special, u_sign_l, u_sign_s;
   logic [63:0]       u_early_result;
   logic [EXP_W-1:0]  u_exp_l, u_diff;
   logic [MANT_W-1:0] u_mant_l, u_mant_s;

   logic [MANT_W-1:0] sum;
   logic [EXP_W-1:0]  exp_dec;

   fp_operand_unpack #(.MANT_W(MANT_W)) u_unpack (
      .a            (a_q),
      .b            (b_q),
      .sub          (sub_q),
      .early        (u_early),
      .special      (u_special),
      .early_result (u_early_result),
      .sign_l       (u_sign_l),
      .sign_s       (u_sign_s),
      .exp_l        (u_exp_l),
      .diff         (u_diff),
      .mant_l       (u_mant_l),
      .mant_s       (u_mant_s)
   );

   // Operands are magnitude-ordered, so the subtraction never goes negative.
   assign sum     = (sign_a == sign_b) ? ma + mb : ma - mb;
   assign exp_dec = exp_r - 11'd1;
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_UNPACK;
         S_UNPACK: state_nx = u_early ? S_DONE : S_ALIGN;
         S_ALIGN:  if (cnt == '0) state_nx = S_ADD;
         S_ADD:    state_nx = (sum == '0) ? S_DONE : S_NORM;
         S_NORM: begin
            if (m[CARRY] || m[HIDDEN]) state_nx = S_PACK;
            else if (exp_dec == '0)    state_nx = S_DONE;
         end
         S_PACK:   state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         exp_r   <= '0;
         cnt     <= '0;
         ma      <= '0;
         mb      <= '0;
         m       <= '0;
         result  <= '0;
         invalid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sub_q   <= sub;
                  invalid <= 1'b0;
               end
            end
            S_UNPACK: begin
               if (u_early) begin
                  result  <= u_early_result;
                  invalid <= u_special;
               end else begin
                  sign_a <= u_sign_l;
                  sign_b <= u_sign_s;
                  exp_r  <= u_exp_l;
                  ma     <= u_mant_l;
                  // Shifting past the register would only burn cycles to reach zero.
                  if (u_diff >= EXP_W'(MANT_W)) begin
                     mb  <= '0;
                     cnt <= '0;
                  end else begin
                     mb  <= u_mant_s;
                     cnt <= u_diff;
                  end
               end
            end
            S_ALIGN: begin
               if (cnt != '0) begin
                  mb  <= mb >> 1;
                  cnt <= cnt - 11'd1;
               end
            end
            S_ADD: begin
               m <= sum;
               if (sum == '0) result <= '0;
            end
            S_NORM: begin
               if (m[CARRY]) begin
                  m     <= m >> 1;
                  exp_r <= exp_r + 11'd1;
               end else if (!m[HIDDEN]) begin
                  if (exp_dec == '0) begin
                     result <= {sign_a, 63'd0};
                  end else begin
                     m     <= m << 1;
                     exp_r <= exp_dec;
                  end
               end
            end
            S_PACK: begin
               if (exp_r == EXP_MAX) result <= {sign_a, EXP_MAX, {FRAC_W{1'b0}}};
               else                  result <= {sign_a, exp_r, m[HIDDEN-1 -: FRAC_W]};
            end
            default: ;
         endcase
      end
   end

endmodule
